// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          Req;
  logic          MW;
  logic [AW-1:0] Addr;
  logic [DW-1:0] WData;
  logic [DW-1:0] RData;
  logic          LMC;
  logic          Busy;
  logic          Err;

  modport master (output Req, MW, Addr, WData, input RData, LMC, Busy, Err);
  modport slave  (input Req, MW, Addr, WData, output RData, LMC, Busy, Err);
endinterface

// File: rtl/mem_responder.sv
// Wait-stated register-array memory slave with a one-cycle completion pulse.
// Optional address range checking is enabled by defining MEM_RESPONDER_ERR_EN.
module mem_responder #(
  parameter int DW          = 16,
  parameter int AW          = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  mem_responder_if.slave bus
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          mw_q, mw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          lmc_q, lmc_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [DW-1:0] mem [DEPTH];

  logic          acc_mw;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          resp_entry;
  logic          addr_bad;
  logic          mem_we;

  // acc_* is the access being completed: live inputs when RESP is entered
  // straight from IDLE (zero wait states), latched values otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mw_d      = mw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc_mw    = mw_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          mw_d      = bus.MW;
          addr_d    = bus.Addr;
          wdata_d   = bus.WData;
          acc_mw    = bus.MW;
          acc_addr  = bus.Addr;
          acc_wdata = bus.WData;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_entry = (state_d == RESP) && (state_q != RESP);

`ifdef MEM_RESPONDER_ERR_EN
    addr_bad = (acc_addr >> IW) != '0;
`else
    addr_bad = 1'b0;
`endif

    rdata_d = rdata_q;
    if (resp_entry) begin
      if (addr_bad) begin
        rdata_d = '0;
      end else if (!acc_mw) begin
        rdata_d = mem[acc_addr[IW-1:0]];
      end
    end

    lmc_d  = (state_d == RESP);
    busy_d = (state_d != IDLE);
    err_d  = resp_entry && addr_bad;
  end

`ifndef MEM_RESPONDER_ERR_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr;
`endif

  // RESET gates the write so a zero-wait request seen while reset is held
  // cannot reach storage.
  assign mem_we = RESET && resp_entry && acc_mw && !addr_bad;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[acc_addr[IW-1:0]] <= acc_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lmc_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mw_q    <= mw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lmc_q   <= lmc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.RData = rdata_q;
  assign bus.LMC   = lmc_q;
  assign bus.Busy  = busy_q;
  assign bus.Err   = err_q;

endmodule
